// File: rtl/movement_pkg.sv
// Shared state codes and default tuning constants for the character motion block.
package movement_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WALK    = 3'd1,
    ST_JUMP    = 3'd2,
    ST_FALL    = 3'd3,
    ST_CLIMB   = 3'd4,
    ST_RESPAWN = 3'd5
  } move_state_t;

  localparam int XW_DEF       = 11;
  localparam int STEP_DIV_DEF = 50000;
  localparam int GRAV_DIV_DEF = 200000;
  localparam int JUMP_V0_DEF  = 6;
  localparam int VMAX_DEF     = 8;
  localparam int X_MIN_DEF    = 0;
  localparam int X_MAX_DEF    = 976;
  localparam int INIT_X_DEF   = 64;
  localparam int INIT_Y_DEF   = 700;

endpackage

// File: rtl/tick_gen.sv
// Free-running 0..DIV-1 counter; tick is high while the count sits at DIV-1.
// hold freezes the count, clr restarts it from zero (clr wins over hold).
module tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic hold,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (!hold) begin
      cnt <= tick ? '0 : cnt + CNT_ONE;
    end
  end

endmodule

// File: rtl/character_movement.sv
// Character motion FSM (walk/jump/fall/climb/respawn) with registered position and status.
// Define CHAR_MOVE_AIR_CONTROL_EN to allow left/right steering while airborne.
module character_movement
  import movement_pkg::*;
#(
  parameter int XW       = XW_DEF,
  parameter int STEP_DIV = STEP_DIV_DEF,
  parameter int GRAV_DIV = GRAV_DIV_DEF,
  parameter int JUMP_V0  = JUMP_V0_DEF,
  parameter int VMAX     = VMAX_DEF,
  parameter int X_MIN    = X_MIN_DEF,
  parameter int X_MAX    = X_MAX_DEF,
  parameter int INIT_X   = INIT_X_DEF,
  parameter int INIT_Y   = INIT_Y_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          freeze,
  input  logic          left,
  input  logic          right,
  input  logic          jump,
  input  logic          up,
  input  logic          down,
  input  logic          hit,
  input  logic          ladder_ok,
  input  logic [XW-1:0] ladder_top,
  input  logic [XW-1:0] ladder_bot,
  input  logic [XW-1:0] ground_y,
  output logic [XW-1:0] xpos,
  output logic [XW-1:0] ypos,
  output logic [2:0]    mstate,
  output logic          on_ladder,
  output logic          airborne
);

  localparam int VPEAK = (JUMP_V0 > VMAX) ? JUMP_V0 : VMAX;
  localparam int VW    = $clog2(VPEAK + 1);

  localparam logic [XW-1:0] XMIN_C = XW'(X_MIN);
  localparam logic [XW-1:0] XMAX_C = XW'(X_MAX);
  localparam logic [XW-1:0] XINIT  = XW'(INIT_X);
  localparam logic [XW-1:0] YINIT  = XW'(INIT_Y);
  localparam logic [XW-1:0] X_ONE  = XW'(1);
  localparam logic [VW-1:0] V0_C   = VW'(JUMP_V0);
  localparam logic [VW-1:0] VMAX_C = VW'(VMAX);
  localparam logic [VW-1:0] V_ONE  = VW'(1);

  move_state_t   state, state_n;
  logic [XW-1:0] x_q, y_q, x_n, y_n, x_step, vel_x;
  logic [XW:0]   y_sum;
  logic [VW-1:0] vel, vel_n;
  logic          step_tick, grav_tick, tick_clr;
  logic          l, r, j, u, d;

  // Player commands are dead while the game is not running.
  assign l = left  & enable;
  assign r = right & enable;
  assign j = jump  & enable;
  assign u = up    & enable;
  assign d = down  & enable;

  assign vel_x = XW'(vel);
  assign y_sum = {1'b0, y_q} + {1'b0, vel_x};

  assign tick_clr = (state_n != state);

  tick_gen #(.DIV(STEP_DIV)) u_step (
    .clk(clk), .rst(rst), .hold(freeze), .clr(tick_clr), .tick(step_tick)
  );

  tick_gen #(.DIV(GRAV_DIV)) u_grav (
    .clk(clk), .rst(rst), .hold(freeze), .clr(tick_clr), .tick(grav_tick)
  );

  always_comb begin
    x_step = x_q;
    if (l && !r && (x_q > XMIN_C)) begin
      x_step = x_q - X_ONE;
    end else if (r && !l && (x_q < XMAX_C)) begin
      x_step = x_q + X_ONE;
    end
  end

  always_comb begin
    state_n = state;
    x_n     = x_q;
    y_n     = y_q;
    vel_n   = vel;
    if (hit) begin
      state_n = ST_RESPAWN;
      x_n     = XINIT;
      y_n     = YINIT;
      vel_n   = '0;
    end else if (!freeze) begin
      case (state)
        ST_RESPAWN: begin
          x_n     = XINIT;
          y_n     = YINIT;
          vel_n   = '0;
          state_n = ST_IDLE;
        end
        ST_IDLE: begin
          if (y_q < ground_y) begin
            state_n = ST_FALL;
            vel_n   = '0;
          end else if (j) begin
            state_n = ST_JUMP;
            vel_n   = V0_C;
          end else if ((u && ladder_ok && (y_q > ladder_top)) ||
                       (d && ladder_ok && (y_q < ladder_bot))) begin
            state_n = ST_CLIMB;
          end else if (l ^ r) begin
            state_n = ST_WALK;
          end
        end
        ST_WALK: begin
          if (y_q < ground_y) begin
            state_n = ST_FALL;
            vel_n   = '0;
          end else if (j) begin
            state_n = ST_JUMP;
            vel_n   = V0_C;
          end else if (l == r) begin
            state_n = ST_IDLE;
          end else if (step_tick) begin
            x_n = x_step;
          end
        end
        ST_JUMP: begin
`ifdef CHAR_MOVE_AIR_CONTROL_EN
          if (step_tick) x_n = x_step;
`endif
          if (grav_tick) begin
            y_n = (y_q >= vel_x) ? (y_q - vel_x) : '0;
            // The tick that spends the last unit of velocity is the apex.
            if (vel <= V_ONE) begin
              state_n = ST_FALL;
              vel_n   = '0;
            end else begin
              vel_n = vel - V_ONE;
            end
          end
        end
        ST_FALL: begin
`ifdef CHAR_MOVE_AIR_CONTROL_EN
          if (step_tick) x_n = x_step;
`endif
          if (grav_tick) begin
            y_n   = (y_sum > {1'b0, ground_y}) ? ground_y : y_sum[XW-1:0];
            vel_n = (vel >= VMAX_C) ? VMAX_C : (vel + V_ONE);
            if (y_n == ground_y) begin
              state_n = ST_IDLE;
              vel_n   = '0;
            end
          end
        end
        ST_CLIMB: begin
          if (!ladder_ok) begin
            state_n = ST_FALL;
            vel_n   = '0;
          end else if (u == d) begin
            state_n = ST_IDLE;
          end else if (u) begin
            if (y_q <= ladder_top) begin
              state_n = ST_IDLE;
            end else if (step_tick) begin
              y_n = y_q - X_ONE;
              if (y_n == ladder_top) state_n = ST_IDLE;
            end
          end else begin
            if (y_q >= ladder_bot) begin
              state_n = ST_IDLE;
            end else if (step_tick) begin
              y_n = y_q + X_ONE;
              if (y_n == ladder_bot) state_n = ST_IDLE;
            end
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      x_q       <= XINIT;
      y_q       <= YINIT;
      vel       <= '0;
      on_ladder <= 1'b0;
      airborne  <= 1'b0;
    end else begin
      state     <= state_n;
      x_q       <= x_n;
      y_q       <= y_n;
      vel       <= vel_n;
      on_ladder <= (state_n == ST_CLIMB);
      airborne  <= (state_n == ST_JUMP) || (state_n == ST_FALL);
    end
  end

  assign xpos   = x_q;
  assign ypos   = y_q;
  assign mstate = state;

endmodule
